uart_rx_sequencer: RTL and testbench
====================================

Name: uart_rx_sequencer

Overview:
Receive-side control FSM for the UART receiver. It oversamples the serial line, detects and validates the start bit, and shifts in the data bits. It then checks the parity and stop bits and drives stop_enable, which gates the parity-checked byte onto the receiver output bus. It also reports the frame status (valid, parity error, framing error) to the host side.

Parameters:
DATA_BITS, 8, number of data bits per frame, sent LSB first.
OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and at least 4.
PARITY_EN, 1, 1 = a parity bit follows the data; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity; 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
baud_tick  input  1  one-clk strobe at OVERSAMPLE x baud rate
rx  input  1  asynchronous serial line, idle high
data_out  output  DATA_BITS  last received byte; holds until the next accepted frame
stop_enable  output  1  one-clk pulse; byte accepted and may be driven onto the output bus
parity_error  output  1  one-clk pulse at end of a frame with a parity mismatch
framing_error  output  1  one-clk pulse at end of a frame whose stop bit sampled 0
busy  output  1  high in every state except IDLE

Behaviour:
- Synchronisation: rx passes through a 2-flop synchroniser, rx_s; both flops reset to 1. All decisions use rx_s, so there is 2-clk latency from rx to the FSM.
- Reset (rst=1 on a clk edge): state=IDLE, tick counter=0, bit counter=0, shift register=0, data_out=0, stop_enable=0, parity_error=0, framing_error=0, busy=0. Reset mid-frame abandons the frame with no status pulse.
- The FSM advances only on clk edges where baud_tick=1. Counters hold when baud_tick=0.
- Tick counter: counts 0..OVERSAMPLE-1 and wraps to 0.
- IDLE: on a tick with rx_s=0, go to START and clear the tick counter.
- START: on the tick where the counter reaches OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: go to DATA, clear the tick counter and bit counter.
  - rx_s=1: treat as a glitch and return to IDLE. No outputs.
- DATA: on each tick where the counter reaches OVERSAMPLE-1 (mid data bit):
  - Shift rx_s into the MSB of the shift register, shifting right, so the first bit received ends in bit 0.
  - Increment the bit counter.
  - After DATA_BITS samples, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: at counter OVERSAMPLE-1, latch par_bad = (XOR of the data bits XOR the sampled bit) != PARITY_ODD. Go to STOP.
- STOP: at counter OVERSAMPLE-1, sample the stop bit, then go to IDLE on the same edge. Exactly one outcome, in this priority:
  - stop bit = 0: framing_error=1 for 1 clk. data_out unchanged. parity_error is not asserted.
  - stop bit = 1 and par_bad: parity_error=1 for 1 clk. data_out unchanged.
  - stop bit = 1 and parity good (or PARITY_EN=0): data_out <= shift register and stop_enable=1 on the same edge, for 1 clk.
- Status pulses are registered, last exactly one clk, and are never asserted simultaneously.
- Back-to-back frames: the FSM is in IDLE after the stop-bit sample. A start edge arriving in the second half of the stop bit is detected on the next tick.
- Idle line held low (break): framing_error fires each frame and the FSM re-arms from IDLE. No lockup.
- baud_tick held high continuously is legal; timing then scales to clk.

Test Plan:
- Defaults, frame 0xA5 (bits LSB first 1,0,1,0,0,1,0,1), parity bit 0, stop 1 -> data_out=0xA5; stop_enable high exactly 1 clk; parity_error=0; framing_error=0; busy low after the stop sample.
- Same frame with parity bit 1 -> parity_error 1 clk; stop_enable never high; data_out keeps its previous value (0x00 after reset).
- Frame 0x3C, correct parity 0, stop bit 0 -> framing_error 1 clk; no parity_error; no stop_enable.
- rx low for 4 ticks, then high -> busy pulses high then returns to IDLE; no status pulse; data_out unchanged.
- Back-to-back 0x00 then 0xFF with no idle gap -> two stop_enable pulses; data_out 0x00 then 0xFF.
- rst asserted mid-DATA of frame 0x5A -> all outputs 0 next clk. A subsequent clean 0x81 frame is received correctly.
- PARITY_EN=0, frame 0x7E -> stop_enable asserted one bit period earlier than with parity enabled; data_out=0x7E.

Source files
------------

// File: rtl/uart_rx_sequencer.sv
// Receive-side UART control FSM: synchronises rx, validates the start bit, shifts in data,
// checks parity/stop and emits single-clock accept / parity-error / framing-error pulses.
module uart_rx_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 stop_enable,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  state_t               state_next;
  logic                 rx_meta;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad;
  logic                 mid_start;
  logic                 bit_end;
  logic                 accept_next;
  logic                 perr_next;
  logic                 ferr_next;

  assign mid_start = baud_tick && (tick_cnt == TICK_MID);
  assign bit_end   = baud_tick && (tick_cnt == TICK_LAST);

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (baud_tick && !rx_s) state_next = START;
      START:   if (mid_start) state_next = rx_s ? IDLE : DATA;
      DATA:    if (bit_end && (bit_cnt == BIT_LAST))
                 state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame outcome is decided at the stop-bit sample; framing error takes priority over parity.
  always_comb begin
    busy        = (state != IDLE);
    accept_next = (state == STOP) && bit_end && rx_s && !par_bad;
    perr_next   = (state == STOP) && bit_end && rx_s && par_bad;
    ferr_next   = (state == STOP) && bit_end && !rx_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      par_bad       <= 1'b0;
      data_out      <= '0;
      stop_enable   <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      stop_enable   <= accept_next;
      parity_error  <= perr_next;
      framing_error <= ferr_next;
      if (accept_next) data_out <= shift_reg;
      if (baud_tick) begin
        case (state)
          IDLE: tick_cnt <= '0;
          START: begin
            if (mid_start) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              par_bad  <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            if (bit_end && (state == DATA)) begin
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
            end
            if (bit_end && (state == PARITY))
              par_bad <= ((^shift_reg) ^ rx_s) != PAR_ODD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Scoreboard bench for uart_rx_sequencer: directed frames push expected outcomes,
// a negedge monitor pops and compares whenever a status pulse appears.
module tb_uart_rx_sequencer;

  localparam int OS       = 16;
  localparam int BIT_CLKS = OS * 2;
  localparam logic [1:0] K_ACCEPT = 2'd1;
  localparam logic [1:0] K_PAR    = 2'd2;
  localparam logic [1:0] K_FRAME  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_np = 1'b1;
  logic [7:0] data_out, data_out_np;
  logic       stop_enable, parity_error, framing_error, busy;
  logic       stop_enable_np, parity_error_np, framing_error_np, busy_np;

  exp_t   q0[$];
  exp_t   q1[$];
  int     n_checks = 0;
  int     n_fail = 0;
  longint cycle = 0;
  longint t_acc0 = -1;
  longint t_acc1 = -1;

  uart_rx_sequencer dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
    .data_out(data_out), .stop_enable(stop_enable), .parity_error(parity_error),
    .framing_error(framing_error), .busy(busy)
  );

  uart_rx_sequencer #(.PARITY_EN(0)) dut_np (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_np),
    .data_out(data_out_np), .stop_enable(stop_enable_np), .parity_error(parity_error_np),
    .framing_error(framing_error_np), .busy(busy_np)
  );

  always #5 clk = ~clk;

  // One tick every other clock, so the DUT must also hold its counters between ticks.
  always @(posedge clk) begin
    baud_tick <= ~baud_tick;
    cycle     <= cycle + 1;
  end

  task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  task automatic check_output(input int which, input logic se, input logic pe, input logic fe,
                              input logic [7:0] dout);
    exp_t       e;
    logic [1:0] kind;
    int         npulse;
    npulse = int'(se) + int'(pe) + int'(fe);
    kind   = se ? K_ACCEPT : (pe ? K_PAR : K_FRAME);
    check_value($sformatf("pulses_exclusive%0d", which), 32'(npulse), 32'd1);
    if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL unexpected_pulse%0d: got kind %0d, expected no pulse at cycle %0d", which, kind, cycle);
      return;
    end
    if (which == 0) e = q0.pop_front();
    else            e = q1.pop_front();
    check_value($sformatf("kind%0d", which), 32'(kind), 32'(e.kind));
    check_value($sformatf("data_out%0d", which), 32'(dout), 32'(e.data));
  endtask

  always @(negedge clk) begin
    if (stop_enable || parity_error || framing_error)
      check_output(0, stop_enable, parity_error, framing_error, data_out);
    if (stop_enable_np || parity_error_np || framing_error_np)
      check_output(1, stop_enable_np, parity_error_np, framing_error_np, data_out_np);
    if (stop_enable)    t_acc0 = cycle;
    if (stop_enable_np) t_acc1 = cycle;
  end

  task automatic drive_bit(input int which, input logic v);
    if (which == 0) rx = v;
    else            rx_np = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic apply_stimulus(input int which, input logic [7:0] b, input bit with_par,
                                input logic par_bit, input logic stop_bit,
                                input logic [1:0] kind, input logic [7:0] exp_data);
    exp_t e;
    e.kind = kind;
    e.data = exp_data;
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, b[i]);
    if (with_par) drive_bit(which, par_bit);
    drive_bit(which, stop_bit);
    if (which == 0) rx = 1'b1;
    else            rx_np = 1'b1;
  endtask

  task automatic check_idle(input string name, input logic [7:0] exp_data);
    check_value({name, "_busy"}, 32'(busy), 32'd0);
    check_value({name, "_data"}, 32'(data_out), 32'(exp_data));
  endtask

  task automatic check_reset_outputs(input string name);
    check_value({name, "_data"}, 32'(data_out), 32'd0);
    check_value({name, "_se"}, 32'(stop_enable), 32'd0);
    check_value({name, "_pe"}, 32'(parity_error), 32'd0);
    check_value({name, "_fe"}, 32'(framing_error), 32'd0);
    check_value({name, "_busy"}, 32'(busy), 32'd0);
    check_value({name, "_np_data"}, 32'(data_out_np), 32'd0);
    check_value({name, "_np_busy"}, 32'(busy_np), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle_bits(1);

    $display("[TB] 0xA5 with bad parity bit");
    apply_stimulus(0, 8'hA5, 1'b1, 1'b1, 1'b1, K_PAR, 8'h00);
    idle_bits(2);
    check_idle("par_bad", 8'h00);

    $display("[TB] 0xA5 good frame");
    apply_stimulus(0, 8'hA5, 1'b1, 1'b0, 1'b1, K_ACCEPT, 8'hA5);
    idle_bits(2);
    check_idle("a5_good", 8'hA5);

    $display("[TB] 0x3C with stop bit 0");
    apply_stimulus(0, 8'h3C, 1'b1, 1'b0, 1'b0, K_FRAME, 8'hA5);
    idle_bits(2);
    check_idle("framing", 8'hA5);

    $display("[TB] start glitch");
    rx = 1'b0;
    repeat (8) @(negedge clk);
    check_value("glitch_busy_high", 32'(busy), 32'd1);
    rx = 1'b1;
    idle_bits(1);
    check_idle("glitch", 8'hA5);

    $display("[TB] back-to-back 0x00, 0xFF");
    apply_stimulus(0, 8'h00, 1'b1, 1'b0, 1'b1, K_ACCEPT, 8'h00);
    apply_stimulus(0, 8'hFF, 1'b1, 1'b0, 1'b1, K_ACCEPT, 8'hFF);
    idle_bits(2);
    check_idle("b2b", 8'hFF);

    $display("[TB] reset during 0x5A data bits");
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rx  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    idle_bits(2);
    apply_stimulus(0, 8'h81, 1'b1, 1'b0, 1'b1, K_ACCEPT, 8'h81);
    idle_bits(2);
    check_idle("after_reset", 8'h81);

    $display("[TB] 0x7E with and without parity");
    fork
      apply_stimulus(0, 8'h7E, 1'b1, 1'b0, 1'b1, K_ACCEPT, 8'h7E);
      apply_stimulus(1, 8'h7E, 1'b0, 1'b0, 1'b1, K_ACCEPT, 8'h7E);
    join
    idle_bits(2);
    check_value("np_earlier_by_bit", 32'(t_acc0 - t_acc1), 32'(BIT_CLKS));
    check_value("np_data", 32'(data_out_np), 32'h7E);
    check_value("np_busy", 32'(busy_np), 32'd0);
    check_idle("par_7e", 8'h7E);

    check_value("q0_drained", 32'(q0.size()), 32'd0);
    check_value("q1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
